// File: rtl/twp_master.sv
// Two-Wire Protocol initiator: serializes host read/write commands onto SDA,
// performs the read turnaround and sync hunt, and deserializes read data.
module twp_master #(
    parameter int SYNC_TO = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        SCL,
    inout  wire         SDA,
    input  logic        m_req,
    output logic        m_rdy,
    input  logic        m_cmd,
    input  logic [7:0]  m_addr,
    input  logic [15:0] m_wdata,
    output logic [15:0] m_rdata,
    output logic        m_done,
    output logic        m_err
);

    localparam int TW = (SYNC_TO < 2) ? 1 : $clog2(SYNC_TO);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] turn_cnt;
    logic          prev_one;
    logic          err_q;
    logic          cmd_q;
    logic [7:0]    addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rd_shift;
    logic          sda_o;
    logic          sda_oe;
    logic          sda_hi;
    logic          accept;
    logic          sync_hit;
    logic          turn_exp;

    // Only a solid logic 1 counts as high; a floating or unknown line reads as 0.
    assign sda_hi   = (SDA === 1'b1);
    assign SDA      = sda_oe ? sda_o : 1'bz;
    assign accept   = m_req && (state == S_IDLE);
    assign sync_hit = prev_one && !sda_hi;
    assign turn_exp = (turn_cnt == TW'(SYNC_TO - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_cnt  <= 4'd0;
            turn_cnt <= '0;
            prev_one <= 1'b0;
            err_q    <= 1'b0;
            m_rdata  <= 16'h0000;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= (state_nxt == state) ? bit_cnt + 4'd1 : 4'd0;
            turn_cnt <= (state == S_TURN) ? turn_cnt + TW'(1) : '0;
            prev_one <= (state == S_TURN) && sda_hi;
            if (accept)
                err_q <= 1'b0;
            else if ((state == S_TURN) && !sync_hit && turn_exp)
                err_q <= 1'b1;
            else if ((state == S_STOP) && !sda_hi)
                err_q <= 1'b1;
            // Read data becomes visible in the done cycle, only after a good stop bit.
            if ((state == S_STOP) && sda_hi)
                m_rdata <= rd_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q   <= m_cmd;
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
        end
        if (state == S_RDATA)
            rd_shift <= {sda_hi, rd_shift[15:1]};
    end

    always_comb begin
        state_nxt = state;
        sda_oe    = 1'b1;
        sda_o     = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = S_START;
            end
            S_START: begin
                sda_o     = 1'b0;
                state_nxt = S_CMD;
            end
            S_CMD: begin
                sda_o     = cmd_q;
                state_nxt = S_ADDR;
            end
            S_ADDR: begin
                sda_o = addr_q[bit_cnt[2:0]];
                if (bit_cnt == 4'd7)
                    state_nxt = cmd_q ? S_WDATA : S_TURN;
            end
            S_WDATA: begin
                sda_o = wdata_q[bit_cnt];
                if (bit_cnt == 4'd15)
                    state_nxt = S_DONE;
            end
            S_TURN: begin
                sda_oe = 1'b0;
                if (sync_hit)
                    state_nxt = S_RDATA;
                else if (turn_exp)
                    state_nxt = S_DONE;
            end
            S_RDATA: begin
                sda_oe = 1'b0;
                if (bit_cnt == 4'd15)
                    state_nxt = S_STOP;
            end
            S_STOP: begin
                sda_oe    = 1'b0;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign SCL    = (state != S_IDLE);
    assign m_rdy  = (state == S_IDLE);
    assign m_done = (state == S_DONE);
    assign m_err  = (state == S_DONE) && err_q;

endmodule

// File: doc/twp_master.md
Name: twp_master

Overview:
- Initiator end of the Two-Wire Protocol (TWP); issues the frames that the TWP register-space slave decodes.
- A local host hands over one command at a time (read/write, 8-bit address, 16-bit data).
- The block serializes the command onto SDA, runs the bus turnaround and sync detection for reads, and deserializes the read data.
- It sits on the system/bench side of the SCL/SDA wires, opposite the register arbiter.

Parameters:
SYNC_TO, 8, max cycles spent hunting the slave's 1->0 sync pattern after read turnaround before error abort.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
SCL  output  1  frame-active indicator: 1 from start bit through frame end, else 0 (slave ignores it; debug aid).
SDA  inout  1  TWP data line; block drives it or releases it to z.
m_req  input  1  host command request.
m_rdy  output  1  1 when idle and able to accept m_req.
m_cmd  input  1  1 = write, 0 = read.
m_addr  input  8  register address.
m_wdata  input  16  write data.
m_rdata  output  16  last read data; held until next successful read.
m_done  output  1  one-cycle pulse at frame completion (success or error).
m_err  output  1  valid with m_done: 1 = sync timeout or bad stop bit.

Behaviour:
- Reset (sync, active-high):
  - State IDLE; SDA driven 1; SCL=0, m_rdy=1, m_done=0, m_err=0, m_rdata=0.
  - Reset mid-frame aborts immediately: SDA is driven 1 the next cycle and no m_done is issued.
- Accept: m_req && m_rdy at a clock edge latches cmd, addr and wdata; m_rdy drops the next cycle. m_req while busy is ignored.
- Frame timing, T0 = first cycle after accept. All bits are LSB first and each bit is held exactly one cycle.
  - T0: START, drive SDA=0.
  - T1: CMD, drive cmd bit.
  - T2..T9: ADDR, drive addr[i] at T2+i.
  - Write:
    - T10..T25: WDATA, drive wdata[j] at T10+j.
    - T26: drive SDA=1, m_done=1, m_err=0; back to IDLE. m_rdy=1 from T27.
  - Read:
    - TURN: from T10, SDA=z. Register SDA each cycle and hunt for a sample of 1 followed by a sample of 0.
    - The 0 cycle is the sync end, nominally T13. The first data cycle follows it.
    - No 1->0 pair within SYNC_TO cycles of T10: drive SDA=1, pulse m_done with m_err=1, keep m_rdata, return to IDLE.
    - RDATA: 16 cycles; sample SDA into rdata[j] at the j-th cycle, nominally T14+j.
    - STOP: next cycle (nominally T30), SDA must sample 1; otherwise m_err=1.
    - Next cycle (nominally T31): resume driving SDA=1, load m_rdata (only if no error), pulse m_done, return to IDLE.
- SDA sampling: any value other than logic 1 counts as 0 (z/x never counts as 1).
- SCL=1 during T0 through the done cycle inclusive.
- No back-to-back overlap: a new accept is possible only in the cycle after m_done. This guarantees the slave has returned to its idle state before the next START.
- The block never drives SDA while in TURN, RDATA or STOP (no contention with the slave).

Test Plan:
- Write: host write addr=0x3C, wdata=0xA55A -> SDA shows 0,1, then addr bits LSB first, then data bits LSB first. m_done at T26 with m_err=0. Slave register 0x3C reads back 0xA55A.
- Read: preload slave reg 0x81=0x1234, host read 0x81 -> SDA released at T10, sync 1/0 at T12/T13. m_done at T31 with m_rdata=0x1234, m_err=0.
- Sync timeout: read with no slave attached (SDA stays z) -> m_done at T10+SYNC_TO, m_err=1. m_rdata keeps its prior value. SDA driven 1 the next cycle.
- Bad stop: bench slave model drives 0 at the stop slot -> m_done with m_err=1, m_rdata unchanged.
- Handshake: m_req held high continuously with three queued commands (write 0x10=0xFFFF, read 0x10, write 0x00=0x0001) -> each accept occurs exactly one cycle after the previous m_done. The read returns 0xFFFF.
- Reset mid-frame: assert reset at T5 of a write -> next cycle SDA=1, SCL=0, m_rdy=1, no m_done. A subsequent write after the slave idles completes normally.
